// File: rtl/bus_pkg.sv
// Shared encodings and memory-map constants for the load/store bus demux.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } bus_state_e;

  // Returned on a timed-out response so software sees a recognisable poison value.
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  // Default memory map: addresses 0x1xxx_xxxx are MMIO, everything else data RAM.
  localparam logic [31:0] BUS_SEL_BASE = 32'h1000_0000;
  localparam logic [31:0] BUS_SEL_MASK = 32'hF000_0000;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Response-wait counter: cleared before the wait, counts while enabled, flags expiry.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expires on the last enabled cycle so the response lands TIMEOUT_CYCLES after entry.
  assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                 cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_demux1_2.sv
// Registered 1-to-2 request demux (RAM = target 0, MMIO = target 1), one outstanding txn.
// Optional response timeout enabled by defining BUS_DEMUX_TIMEOUT_EN.
module bus_demux1_2
  import bus_pkg::*;
#(
  parameter int unsigned            WIDTH          = 32,
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  SEL_BASE       = ADDR_WIDTH'(BUS_SEL_BASE),
  parameter logic [ADDR_WIDTH-1:0]  SEL_MASK       = ADDR_WIDTH'(BUS_SEL_MASK),
  parameter int unsigned            TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // initiator
  input  logic                  m_req_valid,
  output logic                  m_req_ready,
  input  logic [ADDR_WIDTH-1:0] m_req_addr,
  input  logic                  m_req_we,
  input  logic [WIDTH-1:0]      m_req_wdata,
  output logic                  m_rsp_valid,
  output logic [WIDTH-1:0]      m_rsp_rdata,
  output logic                  m_rsp_err,
  // target 0
  output logic                  s0_req_valid,
  input  logic                  s0_req_ready,
  output logic [ADDR_WIDTH-1:0] s0_req_addr,
  output logic                  s0_req_we,
  output logic [WIDTH-1:0]      s0_req_wdata,
  input  logic                  s0_rsp_valid,
  input  logic [WIDTH-1:0]      s0_rsp_rdata,
  // target 1
  output logic                  s1_req_valid,
  input  logic                  s1_req_ready,
  output logic [ADDR_WIDTH-1:0] s1_req_addr,
  output logic                  s1_req_we,
  output logic [WIDTH-1:0]      s1_req_wdata,
  input  logic                  s1_rsp_valid,
  input  logic [WIDTH-1:0]      s1_rsp_rdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("bus_demux1_2: TIMEOUT_CYCLES must be at least 1");
  end

  bus_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  req_sel;
  logic                  tgt_ready;
  logic                  tgt_rsp_valid;
  logic [WIDTH-1:0]      tgt_rsp_rdata;
  logic                  to_expired;

  assign req_sel       = ((m_req_addr & SEL_MASK) == SEL_BASE);
  assign tgt_ready     = sel_q ? s1_req_ready : s0_req_ready;
  assign tgt_rsp_valid = sel_q ? s1_rsp_valid : s0_rsp_valid;
  assign tgt_rsp_rdata = sel_q ? s1_rsp_rdata : s0_rsp_rdata;

`ifdef BUS_DEMUX_TIMEOUT_EN
  // Held clear through REQ so the count starts from zero on the first RSP cycle.
  bus_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == REQ),
    .enable  (state_q == RSP),
    .expired (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (m_req_valid) begin
          addr_d  = m_req_addr;
          we_d    = m_req_we;
          wdata_d = m_req_wdata;
          sel_d   = req_sel;
          state_d = REQ;
        end
      end
      REQ: begin
        if (tgt_ready) state_d = RSP;
      end
      RSP: begin
        // A real response beats an expiry landing in the same cycle.
        if (tgt_rsp_valid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : tgt_rsp_rdata;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end else if (to_expired) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = WIDTH'(BUS_ERR_DATA);
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      sel_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign m_req_ready  = (state_q == IDLE);
  assign m_rsp_valid  = rsp_valid_q;
  assign m_rsp_rdata  = rsp_rdata_q;
  assign m_rsp_err    = rsp_err_q;

  // Both targets see the latched request; only the valid is steered.
  assign s0_req_valid = (state_q == REQ) && !sel_q;
  assign s1_req_valid = (state_q == REQ) &&  sel_q;
  assign s0_req_addr  = addr_q;
  assign s0_req_we    = we_q;
  assign s0_req_wdata = wdata_q;
  assign s1_req_addr  = addr_q;
  assign s1_req_we    = we_q;
  assign s1_req_wdata = wdata_q;

endmodule

// File: doc/bus_demux1_2.md
# bus_demux1_2

Registered 1-to-2 request demultiplexer: a single bus initiator (the core's load/store port) talks to two targets, data RAM (target 0) and MMIO (target 1), selected by address decode. One transaction is outstanding at a time. A valid/ready request handshake and a single-cycle response pulse carry the traffic. The block is the sequential counterpart of the datapath result muxes: where those merge sources into one bus, this steers one bus out to two ends and returns the response.

## Interface
Parameters:
- WIDTH, 32, data width of wdata/rdata
- ADDR_WIDTH, 32, address width
- SEL_BASE, 32'h1000_0000, address value that selects target 1
- SEL_MASK, 32'hF000_0000, mask applied to the address before comparing with SEL_BASE
- TIMEOUT_CYCLES, 16, response timeout; used only with BUS_DEMUX_TIMEOUT_EN

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m_req_valid  in  1  initiator request valid
- m_req_ready  out  1  demux can accept a request
- m_req_addr  in  ADDR_WIDTH  request address
- m_req_we  in  1  1 = write, 0 = read
- m_req_wdata  in  WIDTH  write data
- m_rsp_valid  out  1  one-cycle response pulse
- m_rsp_rdata  out  WIDTH  read data (0 for writes)
- m_rsp_err  out  1  timeout error flag
- sN_req_valid  out  1  request valid to target N (N = 0, 1)
- sN_req_ready  in  1  target N accepts the request
- sN_req_addr  out  ADDR_WIDTH  registered address
- sN_req_we  out  1  registered write enable
- sN_req_wdata  out  WIDTH  registered write data
- sN_rsp_valid  in  1  target N response valid
- sN_rsp_rdata  in  WIDTH  target N read data

## Operation
- Target select: sel = ((m_req_addr & SEL_MASK) == SEL_BASE). sel = 1 routes to target 1; otherwise target 0.
- FSM has three states: IDLE, REQ, RSP.
- IDLE:
  - m_req_ready = 1.
  - On m_req_valid, latch addr, we, wdata and sel, then go to REQ.
- REQ:
  - s[sel]_req_valid = 1; the other target's valid = 0.
  - Hold all s*_req_* stable until s[sel]_req_ready = 1, then go to RSP.
- RSP:
  - Wait for s[sel]_rsp_valid.
  - When it arrives, register rdata (forced to 0 if the latched we = 1), pulse m_rsp_valid for one cycle, and go to IDLE.
- Every request gets exactly one response; writes also need a target response, which acts as the ack.
- m_req_ready is 0 in REQ and RSP.
- The following are ignored, with no state change:
  - sN_rsp_valid from the non-selected target.
  - Any sN_rsp_valid while in IDLE or REQ.
- Both sN_req_addr/we/wdata buses carry the latched values; only the valids are steered.

## Timing
- Reset values (async on rst_n = 0): state IDLE, m_req_ready = 1, m_rsp_valid = 0, m_rsp_rdata = 0, m_rsp_err = 0, s0/s1_req_valid = 0, latched addr/we/wdata/sel = 0, timeout count 0.
- Accept at edge T0: s[sel]_req_valid is high from T0+1.
- Target ready at cycle Tr: state is RSP from Tr+1.
- Target rsp_valid at cycle Tk: m_rsp_valid is high at Tk+1 only, and m_req_ready is 1 at Tk+1.
- A new request may be accepted in the same cycle m_rsp_valid is high.
- Minimum turnaround with zero-wait targets:
  - Accept at T0, ready at T1, rsp at T2, m_rsp_valid at T3.
  - So 4 cycles per transaction.
- rst_n asserted mid-transaction: abort immediately; all valids low. No response is ever issued for the aborted request.
- m_req_valid must not be asserted with X address; outputs are undefined in that case.

## Configuration
- Macro: BUS_DEMUX_TIMEOUT_EN.
- Defined:
  - A counter runs in RSP; it clears on entering RSP.
  - If TIMEOUT_CYCLES cycles pass without s[sel]_rsp_valid, pulse m_rsp_valid with m_rsp_err = 1 and m_rsp_rdata = 32'hDEAD_BEEF (zero-extended or truncated to WIDTH), then go to IDLE.
  - A response arriving in the same cycle the count expires wins: normal response, err = 0.
  - m_rsp_err is 0 on normal responses.
- Undefined:
  - No counter; RSP waits indefinitely.
  - m_rsp_err is tied to 0.

## Structure
- Shared package bus_pkg holds:
  - FSM state encoding: IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2.
  - Constant BUS_ERR_DATA = 32'hDEAD_BEEF.
  - Default SEL_BASE/SEL_MASK memory-map constants, shared with the address decoder and the testbench.
- One sub-module, bus_timeout_ctr:
  - Inputs: clear, enable. Output: expired.
  - Parameter TIMEOUT_CYCLES.
  - Instantiated only under BUS_DEMUX_TIMEOUT_EN.

## Test plan
- Read to addr 0x0000_0040, s0 ready and rsp immediate with rdata 0x1234_5678 -> s1_req_valid never high; m_rsp_valid at T3 with rdata 0x1234_5678.
- Write to 0x1000_0004 with wdata 0xA5A5_A5A5, s1 ready after 3 wait cycles -> s1_req_* held stable for 4 cycles; response rdata = 0, m_req_ready low throughout.
- Spurious s1_rsp_valid with 0xFFFF_FFFF during a target-0 transaction -> ignored; only s0's response (0x0000_0001) is returned.
- rst_n pulsed low while in RSP -> outputs reach reset values immediately; a later s0_rsp_valid produces no m_rsp_valid.
- With BUS_DEMUX_TIMEOUT_EN and TIMEOUT_CYCLES = 16, target never responds -> m_rsp_valid with err = 1 and rdata 0xDEAD_BEEF 16 cycles after entering RSP; the next request is accepted normally.
- Back-to-back reads, the second asserted in the same cycle as the first's m_rsp_valid -> second request accepted that cycle; 4-cycle turnaround each.
